// File: rtl/pic_prio_ctrl_n.sv
// Programmable interrupt controller: N_IRQ request lines, fixed/rotating priority, nested ISR,
// two-pulse NINTA acknowledge returning BASE+id. All outputs registered; INT lags IRR by one clk.
module pic_prio_ctrl_n #(
  parameter int N_IRQ = 8,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             NWR,
  input  logic             NRD,
  input  logic [1:0]       A,
  input  logic [15:0]      DIN,
  output logic [15:0]      DOUT,
  input  logic [N_IRQ-1:0] IR,
  output logic             INT,
  input  logic             NINTA,
  output logic [7:0]       VEC,
  output logic             VEC_OE
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACK1 = 2'd1, ACK2 = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [N_IRQ-1:0]   irr_q, irr_d, imr_q, imr_d, isr_q, isr_d, ir_q, req;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [7:0]         base_q, base_d, vec_q, vec_d;
  logic [15:0]        dout_q, dout_d;
  logic [LVL_W-1:0]   lowest_q, lowest_d, id_q, id_d;
  logic [LVL_W-1:0]   cand_idx, cand_rank, top_idx, top_rank, lvl;
  logic               int_q, int_d, vec_oe_q, vec_oe_d, spur_q, spur_d, ninta_q;
  logic               cand_vld, top_vld, lvl_ok, nin_fall;
  logic               din_unused;

  function automatic logic [N_IRQ-1:0] onehot(input int i);
    return N_IRQ'(1) << i;
  endfunction

  // Index of the k-th highest priority line: (lowest+1+k) mod N_IRQ.
  function automatic int rot(input int lo, input int k);
    int r;
    r = lo + 1 + k;
    if (r >= N_IRQ) r = r - N_IRQ;
    return r;
  endfunction

  assign req        = irr_q & ~imr_q;
  assign din_unused = ^DIN;

  // Rank 0 is the highest priority; first hit scanning downward wins.
  always_comb begin
    cand_vld  = 1'b0;
    cand_idx  = '0;
    cand_rank = '0;
    top_vld   = 1'b0;
    top_idx   = '0;
    top_rank  = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      if (!cand_vld && |(req & onehot(rot(int'(lowest_q), k)))) begin
        cand_vld  = 1'b1;
        cand_idx  = LVL_W'(rot(int'(lowest_q), k));
        cand_rank = LVL_W'(k);
      end
      if (!top_vld && |(isr_q & onehot(rot(int'(lowest_q), k)))) begin
        top_vld  = 1'b1;
        top_idx  = LVL_W'(rot(int'(lowest_q), k));
        top_rank = LVL_W'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    imr_d    = imr_q;
    isr_d    = isr_q;
    ctrl_d   = ctrl_q;
    base_d   = base_q;
    dout_d   = dout_q;
    lowest_d = lowest_q;
    vec_d    = vec_q;
    vec_oe_d = vec_oe_q;
    id_d     = id_q;
    spur_d   = spur_q;
    lvl      = DIN[LVL_W-1:0];
    lvl_ok   = (int'(lvl) < N_IRQ);
    nin_fall = !NINTA && ninta_q;
    irr_d    = ctrl_q[0] ? IR : (IR & (irr_q | ~ir_q));
    int_d    = cand_vld && (state_q == IDLE) && (!top_vld || (cand_rank < top_rank));

    if (!NWR) begin
      case (A)
        2'd0: ctrl_d = DIN[2:0];
        2'd1: imr_d  = DIN[N_IRQ-1:0];
        2'd2: base_d = DIN[7:0];
        default: begin
          if (DIN[5] && lvl_ok) lowest_d = lvl;
          if (DIN[7]) begin
            if (DIN[6]) begin
              if (lvl_ok) begin
                isr_d = isr_d & ~onehot(int'(lvl));
                if (ctrl_q[2]) lowest_d = lvl;
              end
            end else if (top_vld) begin
              isr_d = isr_d & ~onehot(int'(top_idx));
              if (ctrl_q[2]) lowest_d = top_idx;
            end
          end
        end
      endcase
    end

    if (!NRD) begin
      dout_d = '0;
      case (A)
        2'd0:    dout_d[N_IRQ-1:0] = irr_q;
        2'd1:    dout_d[N_IRQ-1:0] = imr_q;
        2'd2:    dout_d[N_IRQ-1:0] = isr_q;
        default: dout_d[LVL_W+4:0] = {state_q, ctrl_q, lowest_q};
      endcase
    end

    // EOI commands above are applied before the acknowledge ISR set below.
    case (state_q)
      IDLE: begin
        if (nin_fall) begin
          state_d = ACK1;
          int_d   = 1'b0;
          if (cand_vld) begin
            id_d   = cand_idx;
            spur_d = 1'b0;
            isr_d  = isr_d | onehot(int'(cand_idx));
            if (!ctrl_q[0]) irr_d = irr_d & ~onehot(int'(cand_idx));
          end else begin
            id_d   = LVL_W'(N_IRQ - 1);
            spur_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (nin_fall) begin
          state_d  = ACK2;
          vec_d    = base_q + 8'(id_q);
          vec_oe_d = 1'b1;
        end
      end
      ACK2: begin
        if (NINTA) begin
          state_d  = IDLE;
          vec_oe_d = 1'b0;
          if (ctrl_q[1] && !spur_q) begin
            isr_d = isr_d & ~onehot(int'(id_q));
            if (ctrl_q[2]) lowest_d = id_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      irr_q    <= '0;
      imr_q    <= '0;
      isr_q    <= '0;
      ir_q     <= '0;
      ctrl_q   <= '0;
      base_q   <= '0;
      dout_q   <= '0;
      lowest_q <= LVL_W'(N_IRQ - 1);
      int_q    <= 1'b0;
      vec_q    <= '0;
      vec_oe_q <= 1'b0;
      id_q     <= '0;
      spur_q   <= 1'b0;
      ninta_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      irr_q    <= irr_d;
      imr_q    <= imr_d;
      isr_q    <= isr_d;
      ir_q     <= IR;
      ctrl_q   <= ctrl_d;
      base_q   <= base_d;
      dout_q   <= dout_d;
      lowest_q <= lowest_d;
      int_q    <= int_d;
      vec_q    <= vec_d;
      vec_oe_q <= vec_oe_d;
      id_q     <= id_d;
      spur_q   <= spur_d;
      ninta_q  <= NINTA;
    end
  end

  assign DOUT   = dout_q;
  assign INT    = int_q;
  assign VEC    = vec_q;
  assign VEC_OE = vec_oe_q;

endmodule

// File: tb/tb_pic_prio_ctrl_n.sv
// Bench for pic_prio_ctrl_n: directed scenarios then random operations against a rank-based model.
// Expected reads and vectors are queued at issue time; a monitor compares when DOUT/VEC become valid.
module tb_pic_prio_ctrl_n;
  localparam int N  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset, NWR, NRD, NINTA;
  logic [1:0]    A;
  logic [15:0]   DIN, DOUT;
  logic [N-1:0]  IR;
  logic          INT, VEC_OE;
  logic [7:0]    VEC;

  always #5 clk = ~clk;

  pic_prio_ctrl_n #(.N_IRQ(N), .LVL_W(LW)) dut (
    .clk(clk), .reset(reset), .NWR(NWR), .NRD(NRD), .A(A), .DIN(DIN), .DOUT(DOUT),
    .IR(IR), .INT(INT), .NINTA(NINTA), .VEC(VEC), .VEC_OE(VEC_OE)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: registers as plain vectors, priority as a modular rank.
  logic [N-1:0] m_irr, m_imr, m_isr, m_ir;
  logic [2:0]   m_ctrl;
  logic [7:0]   m_base;
  int           m_low;

  function automatic logic [N-1:0] bitm(input int i);
    return N'(1) << i;
  endfunction

  function automatic int rank(input int i);
    return (i - m_low - 1 + 2 * N) % N;
  endfunction

  function automatic int best(input logic [N-1:0] v);
    int b = -1;
    for (int i = 0; i < N; i++)
      if (|(v & bitm(i)) && (b < 0 || rank(i) < rank(b))) b = i;
    return b;
  endfunction

  function automatic logic model_int();
    int c = best(m_irr & ~m_imr);
    int t = best(m_isr);
    return (c >= 0) && (t < 0 || rank(c) < rank(t));
  endfunction

  function automatic logic [15:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 16'(m_irr);
      2'd1:    return 16'(m_imr);
      2'd2:    return 16'(m_isr);
      default: return {7'd0, 2'b00, m_ctrl, 4'(m_low)};
    endcase
  endfunction

  task automatic m_reset();
    m_irr = '0; m_imr = '0; m_isr = '0; m_ir = '0;
    m_ctrl = '0; m_base = '0; m_low = N - 1;
  endtask

  // Scoreboard queues and monitor.
  logic [15:0] rd_q[$];
  logic [7:0]  vec_q[$];
  logic        rd_seen = 1'b0;
  logic        oe_prev = 1'b0;

  always @(posedge clk) rd_seen <= !NRD && !reset;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) check("dout_unexpected", 1, 0);
      else check("dout", DOUT, rd_q.pop_front());
    end
    if (VEC_OE && !oe_prev) begin
      if (vec_q.size() == 0) check("vec_unexpected", 1, 0);
      else check("vec", VEC, vec_q.pop_front());
    end
    oe_prev = VEC_OE;
  end

  // Drivers: each task starts and ends 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    int lvl, t;
    A = a; DIN = d; NWR = 1'b0;
    tick(1);
    NWR = 1'b1;
    lvl = int'(d[3:0]);
    case (a)
      2'd0: begin m_ctrl = d[2:0]; if (m_ctrl[0]) m_irr = m_ir; end
      2'd1: m_imr = d[N-1:0];
      2'd2: m_base = d[7:0];
      default: begin
        if (d[5] && lvl < N) m_low = lvl;
        if (d[7]) begin
          if (d[6]) begin
            if (lvl < N) begin
              m_isr = m_isr & ~bitm(lvl);
              if (m_ctrl[2]) m_low = lvl;
            end
          end else begin
            t = best(m_isr);
            if (t >= 0) begin
              m_isr = m_isr & ~bitm(t);
              if (m_ctrl[2]) m_low = t;
            end
          end
        end
      end
    endcase
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp);
    rd_q.push_back(exp);
    A = a; NRD = 1'b0;
    tick(1);
    NRD = 1'b1;
  endtask

  task automatic set_ir(input logic [N-1:0] v);
    IR = v;
    if (m_ctrl[0]) m_irr = v;
    else for (int i = 0; i < N; i++) begin
      if (!(|(v & bitm(i)))) m_irr = m_irr & ~bitm(i);
      else if (!(|(m_ir & bitm(i)))) m_irr = m_irr | bitm(i);
    end
    m_ir = v;
    tick(1);
  endtask

  task automatic settle_int(input string name);
    tick(2);
    check(name, INT, model_int());
  endtask

  task automatic ack(input logic [7:0] exp_vec, input bit use_exp);
    int  c, id;
    bit  spur;
    c = best(m_irr & ~m_imr);
    spur = (c < 0);
    id = spur ? N - 1 : c;
    vec_q.push_back(use_exp ? exp_vec : 8'(int'(m_base) + id));
    if (!spur) begin
      m_isr = m_isr | bitm(id);
      if (!m_ctrl[0]) m_irr = m_irr & ~bitm(id);
    end
    NINTA = 1'b0; tick(1);
    check("int_low_after_ack1", INT, 0);
    NINTA = 1'b1; tick(1);
    NINTA = 1'b0; tick(1);
    check("vec_oe_set", VEC_OE, 1);
    tick(1);
    check("vec_oe_hold", VEC_OE, 1);
    NINTA = 1'b1; tick(1);
    check("vec_oe_clear", VEC_OE, 0);
    if (m_ctrl[1] && !spur) begin
      m_isr = m_isr & ~bitm(id);
      if (m_ctrl[2]) m_low = id;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [1:0] ra;
    reset = 1'b1; NWR = 1'b1; NRD = 1'b1; NINTA = 1'b1; A = '0; DIN = '0; IR = '0;
    m_reset();
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state.
    check("rst_int", INT, 0);
    check("rst_vec_oe", VEC_OE, 0);
    check("rst_vec", VEC, 0);
    rd(2'd0, 16'h0000); rd(2'd1, 16'h0000); rd(2'd2, 16'h0000); rd(2'd3, 16'h0007);

    // Single edge request, INT latency, vector BASE+3.
    wr(2'd2, 16'h0040);
    wr(2'd0, 16'h0000);
    set_ir(8'h08);
    check("int_lat_k", INT, 0);
    tick(1);
    check("int_lat_k1", INT, 1);
    ack(8'h43, 1);
    rd(2'd2, 16'h0008); rd(2'd0, 16'h0000);
    wr(2'd3, 16'h0080);
    set_ir(8'h00);
    rd(2'd2, 16'h0000);

    // Two simultaneous requests, nesting released by non-specific EOI.
    set_ir(8'h22);
    settle_int("d3_int_m0");
    check("d3_int_pend", INT, 1);
    ack(8'h41, 1);
    settle_int("d3_int_m1");
    check("d3_int_blocked", INT, 0);
    wr(2'd3, 16'h0080);
    settle_int("d3_int_m2");
    check("d3_int_reassert", INT, 1);
    ack(8'h45, 1);
    wr(2'd3, 16'h0080);
    set_ir(8'h00);
    rd(2'd2, 16'h0000);

    // Nesting against ISR[5], then masking.
    set_ir(8'h20);
    ack(8'h45, 1);
    set_ir(8'h24);
    settle_int("d4_m0");
    check("d4_ir2_outranks", INT, 1);
    set_ir(8'h20);
    set_ir(8'h60);
    settle_int("d4_m1");
    check("d4_ir6_blocked", INT, 0);
    wr(2'd1, 16'h0004);
    set_ir(8'h24);
    settle_int("d4_m2");
    check("d4_masked", INT, 0);
    wr(2'd1, 16'h0000);
    settle_int("d4_m3");
    check("d4_unmasked", INT, 1);
    set_ir(8'h00);
    wr(2'd3, 16'h00C5);
    rd(2'd2, 16'h0000);

    // Automatic EOI with rotation.
    wr(2'd0, 16'h0006);
    set_ir(8'h03);
    tick(1);
    ack(8'h40, 1);
    rd(2'd2, 16'h0000);
    rd(2'd3, 16'h0060);
    ack(8'h41, 1);
    rd(2'd3, 16'h0061);
    set_ir(8'h00);
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0027);
    rd(2'd3, 16'h0007);

    // Level mode: withdrawn request gives the spurious vector.
    wr(2'd0, 16'h0001);
    set_ir(8'h10);
    set_ir(8'h00);
    tick(1);
    ack(8'h47, 1);
    rd(2'd2, 16'h0000);

    // Reset during ACK2 drops VEC_OE at once.
    set_ir(8'h10);
    tick(1);
    vec_q.push_back(8'h44);
    NINTA = 1'b0; tick(1);
    NINTA = 1'b1; tick(1);
    NINTA = 1'b0; tick(1);
    check("d6_vec_oe_before_rst", VEC_OE, 1);
    #5;
    reset = 1'b1;
    #1;
    check("d6_vec_oe_async", VEC_OE, 0);
    check("d6_vec_async", VEC, 0);
    IR = '0; NINTA = 1'b1;
    tick(2);
    reset = 1'b0;
    m_reset();
    tick(1);
    rd(2'd1, 16'h0000); rd(2'd2, 16'h0000); rd(2'd3, 16'h0007);
    check("d6_int_after_rst", INT, 0);

    // Random operations against the model.
    for (int it = 0; it < 250; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1: set_ir(N'($urandom & $urandom));
        2:    wr(2'd1, 16'($urandom_range(0, 255) & $urandom_range(0, 255)));
        3:    wr(2'd0, 16'($urandom));
        4, 5: ack(8'h00, 0);
        6:    wr(2'd3, 16'h0080);
        7:    wr(2'd3, 16'h00C0 | 16'($urandom_range(0, 15)));
        8:    wr(2'd3, 16'h0020 | 16'($urandom_range(0, 15)));
        default: wr(2'd2, 16'($urandom_range(0, 255)));
      endcase
      settle_int("rand_int");
      ra = 2'($urandom_range(0, 3));
      rd(ra, model_rd(ra));
    end

    tick(3);
    check("rd_queue_drained", rd_q.size(), 0);
    check("vec_queue_drained", vec_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
